// File: rtl/tvq_bus_pkg.sv
// Shared definitions for the timer bus slave and the timer core:
// FSM state encoding, register offsets and the one-hot select layout.
package tvq_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_RD   = 3'd2,
        ST_RDH  = 3'd3,
        ST_WR   = 3'd4,
        ST_WRH  = 3'd5,
        ST_DONE = 3'd6
    } tvq_state_t;

    localparam logic [15:0] REG_LIM_OFS = 16'd0;
    localparam logic [15:0] REG_CNT_OFS = 16'd2;
    localparam logic [15:0] REG_CSR_OFS = 16'd4;

    // Bit positions inside the one-hot register select
    localparam int SEL_LIM = 0;
    localparam int SEL_CNT = 1;
    localparam int SEL_CSR = 2;

    typedef struct packed {
        tvq_state_t  state;
        logic [15:1] addr;
        logic        bs;
        logic        odd;
    } tvq_dbg_t;

endpackage

// File: rtl/tvq_bus_if.sv
// Multiplexed address/data bus between a bus master and the timer slave.
interface tvq_bus_if;
    // Handshake: the master raises sync with a valid address (ad_in, bs), then
    // raises din (read) or dout (write, data on ad_in, wtbt = byte) and holds it
    // until the slave answers with rply; the master then drops din/dout and the
    // slave drops rply. Further din/dout phases may follow while sync stays high;
    // dropping sync ends the cycle at any point.
    logic [15:0] bus_ad_in;
    logic        bus_sync;
    logic        bus_din;
    logic        bus_dout;
    logic        bus_wtbt;
    logic        bus_bs;
    logic [15:0] bus_ad_out;
    logic        bus_ad_oe;
    logic        bus_rply;

    modport master (
        output bus_ad_in, bus_sync, bus_din, bus_dout, bus_wtbt, bus_bs,
        input  bus_ad_out, bus_ad_oe, bus_rply
    );

    modport slave (
        input  bus_ad_in, bus_sync, bus_din, bus_dout, bus_wtbt, bus_bs,
        output bus_ad_out, bus_ad_oe, bus_rply
    );
endinterface

// File: rtl/tvq_decode.sv
// Address decoder: maps an I/O-page word address onto a one-hot select of
// the limit, counter and CSR registers.
module tvq_decode
    import tvq_bus_pkg::*;
#(
    parameter logic [15:0] BASE = 16'o177706
) (
    input  logic [15:1] addr,
    input  logic        bs,
    output logic [2:0]  sel
);
    localparam logic [15:0] LIM_ADDR = BASE + REG_LIM_OFS;
    localparam logic [15:0] CNT_ADDR = BASE + REG_CNT_OFS;
    localparam logic [15:0] CSR_ADDR = BASE + REG_CSR_OFS;

    assign sel[SEL_LIM] = bs && (addr == LIM_ADDR[15:1]);
    assign sel[SEL_CNT] = bs && (addr == CNT_ADDR[15:1]);
    assign sel[SEL_CSR] = bs && (addr == CSR_ADDR[15:1]);
endmodule

// File: rtl/tvq_bus.sv
// Bus slave front end for the timer: decodes the three timer registers and
// sequences read/write strobes and the reply handshake.
module tvq_bus
    import tvq_bus_pkg::*;
#(
    parameter logic [15:0] BASE = 16'o177706
) (
    input  logic        tvq_clk,
    input  logic        tvq_reset,
    tvq_bus_if.slave    bus,
    output logic [15:0] tve_din,
    input  logic [15:0] tve_dout,
    output logic        tve_lim_oe,
    output logic        tve_cnt_oe,
    output logic        tve_csr_oe,
    output logic        tve_lim_wr,
    output logic        tve_csr_wr,
    output tvq_dbg_t    dbg
);
    tvq_state_t  state_q;
    logic        sync_q;
    logic [15:1] addr_q;
    logic        bs_q;
    logic        odd_q;
    logic [2:0]  sel_q;
    logic [2:0]  oe_q;
    logic [1:0]  wr_q;
    logic [15:0] ad_out_q;
    logic        ad_oe_q;
    logic        rply_q;
    logic [15:0] din_q;
    logic [2:0]  dec_sel;

    tvq_decode #(.BASE(BASE)) u_decode (
        .addr (bus.bus_ad_in[15:1]),
        .bs   (bus.bus_bs),
        .sel  (dec_sel)
    );

    always_ff @(posedge tvq_clk or posedge tvq_reset) begin
        if (tvq_reset) begin
            state_q  <= ST_IDLE;
            // Treat sync as already high so a sync held across reset is not a new cycle
            sync_q   <= 1'b1;
            addr_q   <= '0;
            bs_q     <= 1'b0;
            odd_q    <= 1'b0;
            sel_q    <= '0;
            oe_q     <= '0;
            wr_q     <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            rply_q   <= 1'b0;
            din_q    <= '0;
        end else begin
            sync_q <= bus.bus_sync;
            oe_q   <= '0;
            wr_q   <= '0;
            if (!bus.bus_sync) begin
                state_q  <= ST_IDLE;
                ad_out_q <= '0;
                ad_oe_q  <= 1'b0;
                rply_q   <= 1'b0;
                din_q    <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!sync_q) begin
                            addr_q <= bus.bus_ad_in[15:1];
                            bs_q   <= bus.bus_bs;
                            odd_q  <= bus.bus_ad_in[0];
                            sel_q  <= dec_sel;
                            if (|dec_sel) state_q <= ST_SEL;
                        end
                    end
                    ST_SEL, ST_DONE: begin
                        if (bus.bus_din && !bus.bus_dout) begin
                            state_q <= ST_RD;
                            oe_q    <= sel_q;
                        end else if (bus.bus_dout && !bus.bus_din) begin
                            state_q <= ST_WR;
                            din_q   <= bus.bus_wtbt ? {8'h00, bus.bus_ad_in[7:0]}
                                                    : bus.bus_ad_in;
                            // Counter is read-only and odd bytes have no backing bits
                            wr_q    <= {sel_q[SEL_CSR], sel_q[SEL_LIM]}
                                       & {2{!(bus.bus_wtbt && odd_q)}};
                        end
                    end
                    ST_RD: begin
                        state_q  <= ST_RDH;
                        ad_out_q <= tve_dout;
                    end
                    ST_RDH: begin
                        if (!bus.bus_din) begin
                            state_q <= ST_DONE;
                            ad_oe_q <= 1'b0;
                            rply_q  <= 1'b0;
                        end else begin
                            ad_oe_q <= 1'b1;
                            rply_q  <= 1'b1;
                        end
                    end
                    ST_WR: begin
                        state_q <= ST_WRH;
                    end
                    ST_WRH: begin
                        if (!bus.bus_dout) begin
                            state_q <= ST_DONE;
                            rply_q  <= 1'b0;
                        end else begin
                            rply_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.bus_ad_out = ad_out_q;
    assign bus.bus_ad_oe  = ad_oe_q;
    assign bus.bus_rply   = rply_q;

    assign tve_din    = din_q;
    assign tve_lim_oe = oe_q[SEL_LIM];
    assign tve_cnt_oe = oe_q[SEL_CNT];
    assign tve_csr_oe = oe_q[SEL_CSR];
    assign tve_lim_wr = wr_q[0];
    assign tve_csr_wr = wr_q[1];

    assign dbg = {state_q, addr_q, bs_q, odd_q};
endmodule

// File: tb/tb_tvq_bus.sv
// Directed bench for the timer bus slave: word/byte reads and writes,
// address misses, DATIO, reset and sync aborts.
module tb_tvq_bus;
    import tvq_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] tve_din;
    logic [15:0] tve_dout = 16'h0000;
    logic        lim_oe, cnt_oe, csr_oe, lim_wr, csr_wr;
    tvq_dbg_t    dbg;
    int          tests_run = 0;
    int          tests_failed = 0;

    tvq_bus_if bus_i ();

    tvq_bus #(.BASE(16'o177706)) dut (
        .tvq_clk    (clk),
        .tvq_reset  (rst),
        .bus        (bus_i),
        .tve_din    (tve_din),
        .tve_dout   (tve_dout),
        .tve_lim_oe (lim_oe),
        .tve_cnt_oe (cnt_oe),
        .tve_csr_oe (csr_oe),
        .tve_lim_wr (lim_wr),
        .tve_csr_wr (csr_wr),
        .dbg        (dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_release();
        bus_i.bus_sync  = 1'b0;
        bus_i.bus_din   = 1'b0;
        bus_i.bus_dout  = 1'b0;
        bus_i.bus_wtbt  = 1'b0;
        bus_i.bus_bs    = 1'b0;
        bus_i.bus_ad_in = 16'h0000;
    endtask

    task automatic start(input logic [15:0] addr, input logic bs);
        bus_i.bus_ad_in = addr;
        bus_i.bus_bs    = bs;
        bus_i.bus_sync  = 1'b1;
        tick();
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic bs,
                      input logic [15:0] data, input logic [2:0] exp_oe, input logic exp_ack);
        tve_dout = data;
        start(addr, bs);
        bus_i.bus_ad_in = 16'h0000;
        bus_i.bus_din   = 1'b1;
        tick();
        chk({tag, ".oe"}, {csr_oe, cnt_oe, lim_oe}, exp_oe);
        chk({tag, ".rply_n"}, bus_i.bus_rply, 1'b0);
        tick();
        chk({tag, ".oe_off"}, {csr_oe, cnt_oe, lim_oe}, 3'b000);
        chk({tag, ".rply_n1"}, bus_i.bus_rply, 1'b0);
        tick();
        chk({tag, ".rply"}, bus_i.bus_rply, exp_ack);
        chk({tag, ".ad_oe"}, bus_i.bus_ad_oe, exp_ack);
        chk({tag, ".data"}, bus_i.bus_ad_out, exp_ack ? data : 16'h0000);
        tick();
        chk({tag, ".hold"}, bus_i.bus_rply, exp_ack);
        bus_i.bus_din = 1'b0;
        tick();
        chk({tag, ".release"}, {bus_i.bus_rply, bus_i.bus_ad_oe}, 2'b00);
        chk({tag, ".state"}, dbg.state, exp_ack ? ST_DONE : ST_IDLE);
        bus_release();
        tick();
        chk({tag, ".idle"}, dbg.state, ST_IDLE);
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic bs,
                      input logic [15:0] data, input logic wtbt, input logic [1:0] exp_wr,
                      input logic [15:0] exp_din, input logic chk_din, input logic exp_ack);
        start(addr, bs);
        bus_i.bus_ad_in = data;
        bus_i.bus_wtbt  = wtbt;
        bus_i.bus_dout  = 1'b1;
        tick();
        chk({tag, ".wr"}, {csr_wr, lim_wr}, exp_wr);
        chk({tag, ".no_oe"}, {csr_oe, cnt_oe, lim_oe}, 3'b000);
        if (chk_din) chk({tag, ".din"}, tve_din, exp_din);
        tick();
        chk({tag, ".wr_off"}, {csr_wr, lim_wr}, 2'b00);
        chk({tag, ".rply_n1"}, bus_i.bus_rply, 1'b0);
        tick();
        chk({tag, ".rply"}, bus_i.bus_rply, exp_ack);
        tick();
        chk({tag, ".hold"}, bus_i.bus_rply, exp_ack);
        bus_i.bus_dout = 1'b0;
        tick();
        chk({tag, ".release"}, bus_i.bus_rply, 1'b0);
        bus_release();
        tick();
        chk({tag, ".idle"}, dbg.state, ST_IDLE);
    endtask

    initial begin
        bus_release();
        #1 rst = 1'b1;
        #1;
        chk("reset.rply", bus_i.bus_rply, 1'b0);
        chk("reset.ad_oe", bus_i.bus_ad_oe, 1'b0);
        chk("reset.ad_out", bus_i.bus_ad_out, 16'h0000);
        chk("reset.tve_din", tve_din, 16'h0000);
        chk("reset.oe", {csr_oe, cnt_oe, lim_oe}, 3'b000);
        chk("reset.wr", {csr_wr, lim_wr}, 2'b00);
        chk("reset.state", dbg.state, ST_IDLE);
        chk("reset.addr", dbg.addr, 15'h0000);
        tick();
        tick();
        rst = 1'b0;
        tick();

        wr("lim_word", 16'o177706, 1'b1, 16'h0005, 1'b0, 2'b01, 16'h0005, 1'b1, 1'b1);
        rd("csr_read", 16'o177712, 1'b1, 16'h0080, 3'b100, 1'b1);
        wr("cnt_write", 16'o177710, 1'b1, 16'h1234, 1'b0, 2'b00, 16'h1234, 1'b1, 1'b1);
        rd("cnt_read", 16'o177710, 1'b1, 16'h4321, 3'b010, 1'b1);
        rd("miss_addr", 16'o177714, 1'b1, 16'h0080, 3'b000, 1'b0);
        rd("miss_bs", 16'o177712, 1'b0, 16'h0080, 3'b000, 1'b0);
        wr("miss_wr_bs", 16'o177706, 1'b0, 16'h00FF, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
        wr("odd_byte", 16'o177713, 1'b1, 16'hAB16, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1);
        wr("even_byte", 16'o177712, 1'b1, 16'hAB16, 1'b1, 2'b10, 16'h0016, 1'b1, 1'b1);

        // DATIO: read then write the CSR under one sync
        tve_dout = 16'h001C;
        start(16'o177712, 1'b1);
        bus_i.bus_ad_in = 16'h0000;
        bus_i.bus_din   = 1'b1;
        tick();
        chk("datio.oe", {csr_oe, cnt_oe, lim_oe}, 3'b100);
        tick();
        tick();
        chk("datio.rd_rply", bus_i.bus_rply, 1'b1);
        chk("datio.rd_data", bus_i.bus_ad_out, 16'h001C);
        bus_i.bus_din = 1'b0;
        tick();
        chk("datio.rd_release", bus_i.bus_rply, 1'b0);
        chk("datio.done", dbg.state, ST_DONE);
        bus_i.bus_ad_in = 16'h0054;
        bus_i.bus_dout  = 1'b1;
        tick();
        chk("datio.wr", {csr_wr, lim_wr}, 2'b10);
        chk("datio.din", tve_din, 16'h0054);
        chk("datio.wr_no_oe", {csr_oe, cnt_oe, lim_oe}, 3'b000);
        tick();
        chk("datio.wr_off", {csr_wr, lim_wr}, 2'b00);
        tick();
        chk("datio.wr_rply", bus_i.bus_rply, 1'b1);
        bus_i.bus_dout = 1'b0;
        tick();
        chk("datio.wr_release", bus_i.bus_rply, 1'b0);
        bus_release();
        tick();
        chk("datio.idle", dbg.state, ST_IDLE);

        // din and dout together in SEL: no action
        start(16'o177706, 1'b1);
        bus_i.bus_din  = 1'b1;
        bus_i.bus_dout = 1'b1;
        tick();
        chk("both.state", dbg.state, ST_SEL);
        chk("both.strobes", {csr_oe, cnt_oe, lim_oe, csr_wr, lim_wr}, 5'b00000);
        tick();
        chk("both.stay", dbg.state, ST_SEL);
        chk("both.rply", bus_i.bus_rply, 1'b0);
        bus_release();
        tick();

        // Asynchronous reset while replying to a read
        tve_dout = 16'h5555;
        start(16'o177706, 1'b1);
        bus_i.bus_din = 1'b1;
        tick();
        chk("rst_rdh.oe", {csr_oe, cnt_oe, lim_oe}, 3'b001);
        tick();
        tick();
        chk("rst_rdh.rply_before", bus_i.bus_rply, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_rdh.rply", bus_i.bus_rply, 1'b0);
        chk("rst_rdh.ad_oe", bus_i.bus_ad_oe, 1'b0);
        chk("rst_rdh.ad_out", bus_i.bus_ad_out, 16'h0000);
        chk("rst_rdh.state", dbg.state, ST_IDLE);
        #1 rst = 1'b0;
        tick();
        tick();
        chk("rst_rdh.no_restart", dbg.state, ST_IDLE);
        chk("rst_rdh.quiet", {bus_i.bus_rply, csr_oe, cnt_oe, lim_oe}, 4'b0000);
        bus_release();
        tick();

        // Sync dropped during the write strobe cycle
        start(16'o177706, 1'b1);
        bus_i.bus_ad_in = 16'h00AA;
        bus_i.bus_dout  = 1'b1;
        tick();
        chk("abort_wr.strobe", {csr_wr, lim_wr}, 2'b01);
        chk("abort_wr.in_wr", dbg.state, ST_WR);
        bus_i.bus_sync = 1'b0;
        tick();
        chk("abort_wr.wr", {csr_wr, lim_wr}, 2'b00);
        chk("abort_wr.rply", bus_i.bus_rply, 1'b0);
        chk("abort_wr.din", tve_din, 16'h0000);
        chk("abort_wr.state", dbg.state, ST_IDLE);
        tick();
        chk("abort_wr.quiet", {bus_i.bus_rply, csr_wr, lim_wr}, 3'b000);
        bus_release();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
